// File: rtl/edge_det_pkg.sv
// Shared definitions for the multi-channel edge detector: edge-mode encodings,
// warm-up counter width and the mode-based event selection helper.
package edge_det_pkg;

  typedef enum logic [1:0] {
    MODE_RISE = 2'b00,
    MODE_FALL = 2'b01,
    MODE_BOTH = 2'b10,
    MODE_OFF  = 2'b11
  } edge_mode_e;

  // Wide enough to count SYNC_STAGES+1 for the largest legal SYNC_STAGES (4)
  localparam int unsigned WARM_W = 3;

  function automatic logic mode_sel(input edge_mode_e m, input logic rise, input logic fall);
    logic sel;
    sel = 1'b0;
    case (m)
      MODE_RISE: sel = rise;
      MODE_FALL: sel = fall;
      MODE_BOTH: sel = rise | fall;
      default:   sel = 1'b0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/edge_det_chan.sv
// One edge-detector channel: synchroniser, optional debounce filter
// (EDGE_DET_DEBOUNCE_EN), edge pulses, sticky flag and saturating counter.
module edge_det_chan
  import edge_det_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned DEB_CYCLES  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_in,
  input  edge_mode_e       i_mode,
  input  logic             i_clr,
  input  logic             i_arm,
  output logic             o_pedge,
  output logic             o_nedge,
  output logic             o_evt,
  output logic             o_sticky,
  output logic [CNT_W-1:0] o_cnt
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_level;
  logic                   r_prev;
  logic                   w_rise;
  logic                   w_fall;
  logic                   r_pedge;
  logic                   r_nedge;
  logic                   r_evt;
  logic                   r_sticky;
  logic [CNT_W-1:0]       r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= '0;
    else        r_sync <= {r_sync[SYNC_STAGES-2:0], i_in};
  end

`ifdef EDGE_DET_DEBOUNCE_EN
  localparam int unsigned DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  logic             r_filt;
  logic [DEB_W-1:0] r_deb;

  // Level flips only after DEB_CYCLES consecutive disagreeing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_filt <= 1'b0;
      r_deb  <= '0;
    end else if (r_sync[SYNC_STAGES-1] != r_filt) begin
      if (r_deb == DEB_LAST) begin
        r_filt <= r_sync[SYNC_STAGES-1];
        r_deb  <= '0;
      end else begin
        r_deb <= r_deb + DEB_W'(1);
      end
    end else begin
      r_deb <= '0;
    end
  end

  assign w_level = r_filt;
`else
  assign w_level = r_sync[SYNC_STAGES-1];
`endif

  assign w_rise = w_level & ~r_prev;
  assign w_fall = ~w_level & r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev  <= 1'b0;
      r_pedge <= 1'b0;
      r_nedge <= 1'b0;
      r_evt   <= 1'b0;
    end else begin
      r_prev  <= w_level;
      r_pedge <= i_arm & w_rise;
      r_nedge <= i_arm & w_fall;
      r_evt   <= i_arm & mode_sel(i_mode, w_rise, w_fall);
    end
  end

  // An event arriving together with clr wins and restarts the count at 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky <= 1'b0;
      r_cnt    <= '0;
    end else if (r_evt) begin
      r_sticky <= 1'b1;
      if (i_clr)             r_cnt <= CNT_W'(1);
      else if (r_cnt != '1)  r_cnt <= r_cnt + CNT_W'(1);
    end else if (i_clr) begin
      r_sticky <= 1'b0;
      r_cnt    <= '0;
    end
  end

  assign o_pedge  = r_pedge;
  assign o_nedge  = r_nedge;
  assign o_evt    = r_evt;
  assign o_sticky = r_sticky;
  assign o_cnt    = r_cnt;

endmodule

// File: rtl/multi_edge_detector.sv
// Multi-channel edge detector top: shared warm-up counter and bus packing.
// Optional debounce filtering is enabled with `define EDGE_DET_DEBOUNCE_EN.
module multi_edge_detector
  import edge_det_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned DEB_CYCLES  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       in,
  input  logic [1:0]             mode,
  input  logic [WIDTH-1:0]       clr,
  output logic [WIDTH-1:0]       pedge,
  output logic [WIDTH-1:0]       nedge,
  output logic [WIDTH-1:0]       evt,
  output logic [WIDTH-1:0]       sticky,
  output logic [WIDTH*CNT_W-1:0] cnt
);

  localparam logic [WARM_W-1:0] WARM_END = WARM_W'(SYNC_STAGES + 1);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || DEB_CYCLES < 1) begin : g_bad_cfg
    $error("multi_edge_detector: SYNC_STAGES must be 2..4 and DEB_CYCLES >= 1");
  end

  logic [WARM_W-1:0] r_warm;
  logic              w_arm;
  edge_mode_e        w_mode;

  assign w_arm  = (r_warm == WARM_END);
  assign w_mode = edge_mode_e'(mode);

  // Pulses stay masked until the sync chain has flushed its reset contents
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_warm <= '0;
    else if (!w_arm) r_warm <= r_warm + WARM_W'(1);
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_chan
    edge_det_chan #(
      .SYNC_STAGES(SYNC_STAGES),
      .CNT_W      (CNT_W),
      .DEB_CYCLES (DEB_CYCLES)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_in    (in[g]),
      .i_mode  (w_mode),
      .i_clr   (clr[g]),
      .i_arm   (w_arm),
      .o_pedge (pedge[g]),
      .o_nedge (nedge[g]),
      .o_evt   (evt[g]),
      .o_sticky(sticky[g]),
      .o_cnt   (cnt[g*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_multi_edge_detector.sv
// Self-checking bench for multi_edge_detector (default build, no debounce):
// directed steps plus random stimulus against a history-based reference model.
module tb_multi_edge_detector;

  localparam int SS = 2;

  logic        clk;
  logic        rst_n;
  logic [7:0]  t_in;
  logic [1:0]  t_mode;
  logic [7:0]  t_clr;
  logic [7:0]  o_pedge, o_nedge, o_evt, o_sticky;
  logic [63:0] o_cnt;

  multi_edge_detector #(
    .WIDTH(8), .SYNC_STAGES(SS), .CNT_W(8), .DEB_CYCLES(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in(t_in), .mode(t_mode), .clr(t_clr),
    .pedge(o_pedge), .nedge(o_nedge), .evt(o_evt), .sticky(o_sticky), .cnt(o_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: input history since reset release, edges since release,
  // expected outputs after the latest edge.
  logic [7:0] hist[$];
  int         k;
  logic [7:0] m_pedge, m_nedge, m_evt, m_sticky;
  int         m_cnt[8];
  int         n_nedge3, n_pedge_any;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] lvl(input int j);
    if (j < 1) return 8'h00;
    return hist[j-1];
  endfunction

  function automatic logic [63:0] cnt_bus();
    logic [63:0] b;
    b = '0;
    for (int c = 0; c < 8; c++) b[c*8 +: 8] = m_cnt[c][7:0];
    return b;
  endfunction

  task automatic check_all();
    chk("pedge",  {56'd0, o_pedge},  {56'd0, m_pedge});
    chk("nedge",  {56'd0, o_nedge},  {56'd0, m_nedge});
    chk("evt",    {56'd0, o_evt},    {56'd0, m_evt});
    chk("sticky", {56'd0, o_sticky}, {56'd0, m_sticky});
    chk("cnt",    o_cnt,             cnt_bus());
  endtask

  task automatic model_clear();
    hist.delete();
    k        = 0;
    m_pedge  = '0;
    m_nedge  = '0;
    m_evt    = '0;
    m_sticky = '0;
    for (int c = 0; c < 8; c++) m_cnt[c] = 0;
  endtask

  task automatic step(input logic [7:0] iv, input logic [1:0] mv, input logic [7:0] cv);
    logic [7:0] r, f, e;
    t_in   = iv;
    t_mode = mv;
    t_clr  = cv;
    @(posedge clk);
    hist.push_back(iv);
    k++;
    for (int c = 0; c < 8; c++) begin
      if (m_evt[c]) begin
        m_sticky[c] = 1'b1;
        m_cnt[c]    = cv[c] ? 1 : ((m_cnt[c] < 255) ? m_cnt[c] + 1 : 255);
      end else if (cv[c]) begin
        m_sticky[c] = 1'b0;
        m_cnt[c]    = 0;
      end
    end
    if (k > SS + 1) begin
      r = lvl(k - SS) & ~lvl(k - SS - 1);
      f = ~lvl(k - SS) & lvl(k - SS - 1);
    end else begin
      r = '0;
      f = '0;
    end
    case (mv)
      2'b00:   e = r;
      2'b01:   e = f;
      2'b10:   e = r | f;
      default: e = '0;
    endcase
    m_pedge = r;
    m_nedge = f;
    m_evt   = e;
    #1;
    check_all();
    if (o_nedge[3]) n_nedge3++;
    if (o_pedge != 8'h00) n_pedge_any++;
  endtask

  // Asserts reset mid-cycle, checks the immediate clear, then releases.
  task automatic do_reset(input logic [7:0] iv);
    rst_n = 1'b0;
    t_in  = iv;
    t_clr = '0;
    model_clear();
    #2;
    check_all();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
  endtask

  logic [7:0] cur;

  initial begin
    rst_n  = 1'b0;
    t_in   = '0;
    t_mode = 2'b00;
    t_clr  = '0;
    model_clear();
    n_nedge3 = 0;
    n_pedge_any = 0;
    @(posedge clk);
    #1;

    // 1: input high through reset release gives no pulses
    do_reset(8'hFF);
    for (int i = 0; i < 10; i++) step(8'hFF, 2'b00, 8'h00);
    chk("t1_pedge", {56'd0, o_pedge}, 64'd0);
    chk("t1_cnt", o_cnt, 64'd0);

    // 2: single rise on channel 0, latency SS+1
    do_reset(8'h00);
    for (int i = 0; i < 5; i++) step(8'h00, 2'b00, 8'h00);
    step(8'h01, 2'b00, 8'h00);
    step(8'h01, 2'b00, 8'h00);
    chk("t2_early", {56'd0, o_pedge}, 64'd0);
    step(8'h01, 2'b00, 8'h00);
    chk("t2_pedge", {56'd0, o_pedge}, 64'd1);
    chk("t2_evt", {56'd0, o_evt}, 64'd1);
    step(8'h01, 2'b00, 8'h00);
    chk("t2_pulse_end", {56'd0, o_pedge}, 64'd0);
    chk("t2_sticky", {63'd0, o_sticky[0]}, 64'd1);
    chk("t2_cnt0", {56'd0, o_cnt[7:0]}, 64'd1);

    // 3: both-edge counting saturates on channel 3
    cur = 8'h01;
    n_nedge3 = 0;
    for (int i = 0; i < 300; i++) begin
      cur[3] = ~cur[3];
      for (int j = 0; j < 4; j++) step(cur, 2'b10, 8'h00);
    end
    for (int j = 0; j < 4; j++) step(cur, 2'b10, 8'h00);
    chk("t3_cnt3_sat", {56'd0, o_cnt[31:24]}, 64'd255);
    chk("t3_nedge3_total", 64'(n_nedge3), 64'd150);

    // 4: clr coinciding with evt on channel 2 (fall mode)
    cur = 8'h05;
    for (int j = 0; j < 4; j++) step(cur, 2'b01, 8'h00);
    cur = 8'h01;
    for (int j = 0; j < 4; j++) step(cur, 2'b01, 8'h00);
    chk("t4_cnt2_pre", {56'd0, o_cnt[23:16]}, 64'd1);
    cur = 8'h05;
    for (int j = 0; j < 4; j++) step(cur, 2'b01, 8'h00);
    cur = 8'h01;
    step(cur, 2'b01, 8'h00);
    step(cur, 2'b01, 8'h00);
    step(cur, 2'b01, 8'h00);
    chk("t4_evt2", {63'd0, o_evt[2]}, 64'd1);
    step(cur, 2'b01, 8'h04);
    chk("t4_sticky2_win", {63'd0, o_sticky[2]}, 64'd1);
    chk("t4_cnt2_win", {56'd0, o_cnt[23:16]}, 64'd1);
    step(cur, 2'b01, 8'h04);
    chk("t4_sticky2_clr", {63'd0, o_sticky[2]}, 64'd0);
    chk("t4_cnt2_clr", {56'd0, o_cnt[23:16]}, 64'd0);

    // 5: mode off with random toggles
    do_reset(8'h00);
    n_pedge_any = 0;
    for (int i = 0; i < 100; i++) begin
      step(8'($urandom), 2'b11, 8'h00);
      chk("t5_evt_off", {56'd0, o_evt}, 64'd0);
    end
    chk("t5_sticky_off", {56'd0, o_sticky}, 64'd0);
    chk("t5_cnt_off", o_cnt, 64'd0);
    chk("t5_pedge_seen", 64'(n_pedge_any > 0), 64'd1);

    // 6: random mixed traffic with a reset in the middle
    for (int i = 0; i < 300; i++) begin
      if (i == 150) do_reset(8'($urandom));
      step(8'($urandom), 2'($urandom), ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
